// File: rtl/qec_link_pkg.sv
// Shared types and sizing helpers for the leaf/hub link endpoint.
// Beat count and counter width are derived from message and PHY widths.
package qec_link_pkg;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int beat_cnt_w(input int num_beats);
    return $clog2(num_beats + 1);
  endfunction

  localparam int DEF_MSG_WIDTH  = 20;
  localparam int DEF_PHY_WIDTH  = 8;
  localparam int DEF_BEAT_CNT_W = beat_cnt_w(ceil_div(DEF_MSG_WIDTH, DEF_PHY_WIDTH));

endpackage

// File: rtl/link_beat_deserializer.sv
// RX path: reassembles LSB-first PHY beats into one message and holds it
// until the local consumer takes it; the hub is stalled while a message is held.
module link_beat_deserializer
  import qec_link_pkg::*;
#(
  parameter int MSG_WIDTH = DEF_MSG_WIDTH,
  parameter int PHY_WIDTH = DEF_PHY_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic [PHY_WIDTH-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [MSG_WIDTH-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 busy_o
);

  localparam int NUM_BEATS = ceil_div(MSG_WIDTH, PHY_WIDTH);
  localparam int BW        = beat_cnt_w(NUM_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  rx_state_e              state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [MSG_WIDTH-1:0]   asm_q, asm_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_COLLECT;
      beat_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    if (flush_i) begin
      state_d = RX_COLLECT;
      beat_d  = '0;
      asm_d   = '0;
    end else begin
      case (state_q)
        RX_COLLECT: begin
          if (in_valid_i) begin
            // Only message bits are written, so last-beat padding falls away.
            for (int j = 0; j < MSG_WIDTH; j++) begin
              if (beat_q == BW'(j / PHY_WIDTH)) asm_d[j] = in_data_i[j % PHY_WIDTH];
            end
            if (beat_q == LAST_BEAT) state_d = RX_HOLD;
            else                     beat_d  = beat_q + 1'b1;
          end
        end
        RX_HOLD: begin
          if (rx_ready_i) begin
            state_d = RX_COLLECT;
            beat_d  = '0;
          end
        end
        default: state_d = RX_COLLECT;
      endcase
    end
  end

  assign in_ready_o = (state_q == RX_COLLECT);
  assign rx_valid_o = (state_q == RX_HOLD);
  assign rx_data_o  = asm_q;
  assign busy_o     = (state_q == RX_HOLD) || (beat_q != '0);

endmodule

// File: rtl/upstream_link_endpoint.sv
// Leaf-side link endpoint: serialises local messages to the hub, reassembles
// hub beats for the local controller, and reports convergence status upward.
module upstream_link_endpoint
  import qec_link_pkg::*;
#(
  parameter  int MSG_WIDTH = DEF_MSG_WIDTH,
  parameter  int PHY_WIDTH = DEF_PHY_WIDTH,
  localparam int NUM_BEATS = ceil_div(MSG_WIDTH, PHY_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [MSG_WIDTH-1:0] local_tx_data,
  input  logic                 local_tx_valid,
  output logic                 local_tx_ready,
  output logic [MSG_WIDTH-1:0] local_rx_data,
  output logic                 local_rx_valid,
  input  logic                 local_rx_ready,
  input  logic                 local_has_message_flying,
  input  logic                 local_has_odd_clusters,
  output logic [PHY_WIDTH-1:0] upstream_fifo_out_data,
  output logic                 upstream_fifo_out_valid,
  input  logic                 upstream_fifo_out_ready,
  input  logic [PHY_WIDTH-1:0] upstream_fifo_in_data,
  input  logic                 upstream_fifo_in_valid,
  output logic                 upstream_fifo_in_ready,
  output logic                 upstream_has_message_flying,
  output logic                 upstream_has_odd_clusters
);

  localparam int BW = beat_cnt_w(NUM_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  tx_state_e            tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_beat_q, tx_beat_d;
  logic [MSG_WIDTH-1:0] tx_msg_q, tx_msg_d;
  logic                 flying_q, flying_d;
  logic                 odd_q;
  logic                 rx_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_beat_q  <= '0;
      tx_msg_q   <= '0;
      flying_q   <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_beat_q  <= tx_beat_d;
      tx_msg_q   <= tx_msg_d;
      flying_q   <= flush ? 1'b0 : flying_d;
      odd_q      <= flush ? 1'b0 : local_has_odd_clusters;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_beat_d  = tx_beat_q;
    tx_msg_d   = tx_msg_q;
    if (flush) begin
      tx_state_d = TX_IDLE;
      tx_beat_d  = '0;
      tx_msg_d   = '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (local_tx_valid) begin
            tx_msg_d   = local_tx_data;
            tx_beat_d  = '0;
            tx_state_d = TX_SEND;
          end
        end
        TX_SEND: begin
          if (upstream_fifo_out_ready) begin
            if (tx_beat_q == LAST_BEAT) begin
              tx_state_d = TX_IDLE;
              tx_beat_d  = '0;
            end else begin
              tx_beat_d  = tx_beat_q + 1'b1;
            end
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  // Beat slice of the held message; bits beyond MSG_WIDTH stay zero.
  always_comb begin
    upstream_fifo_out_data = '0;
    if (tx_state_q == TX_SEND) begin
      for (int j = 0; j < MSG_WIDTH; j++) begin
        if (tx_beat_q == BW'(j / PHY_WIDTH)) upstream_fifo_out_data[j % PHY_WIDTH] = tx_msg_q[j];
      end
    end
  end

  assign local_tx_ready          = (tx_state_q == TX_IDLE);
  assign upstream_fifo_out_valid = (tx_state_q == TX_SEND);

  assign flying_d = local_has_message_flying || (tx_state_q != TX_IDLE) || local_tx_valid
                 || rx_busy || upstream_fifo_in_valid;

  assign upstream_has_message_flying = flying_q;
  assign upstream_has_odd_clusters   = odd_q;

  link_beat_deserializer #(
    .MSG_WIDTH (MSG_WIDTH),
    .PHY_WIDTH (PHY_WIDTH)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .in_data_i  (upstream_fifo_in_data),
    .in_valid_i (upstream_fifo_in_valid),
    .in_ready_o (upstream_fifo_in_ready),
    .rx_data_o  (local_rx_data),
    .rx_valid_o (local_rx_valid),
    .rx_ready_i (local_rx_ready),
    .busy_o     (rx_busy)
  );

endmodule

// File: tb/tb_upstream_link_endpoint.sv
// Directed, table-driven bench for upstream_link_endpoint at MSG_WIDTH=20, PHY_WIDTH=8.
module tb_upstream_link_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [19:0] local_tx_data;
  logic        local_tx_valid;
  logic        local_tx_ready;
  logic [19:0] local_rx_data;
  logic        local_rx_valid;
  logic        local_rx_ready;
  logic        local_has_message_flying;
  logic        local_has_odd_clusters;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        up_flying;
  logic        up_odd;

  always #5 clk = ~clk;

  upstream_link_endpoint #(.MSG_WIDTH(20), .PHY_WIDTH(8)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .flush                       (flush),
    .local_tx_data               (local_tx_data),
    .local_tx_valid              (local_tx_valid),
    .local_tx_ready              (local_tx_ready),
    .local_rx_data               (local_rx_data),
    .local_rx_valid              (local_rx_valid),
    .local_rx_ready              (local_rx_ready),
    .local_has_message_flying    (local_has_message_flying),
    .local_has_odd_clusters      (local_has_odd_clusters),
    .upstream_fifo_out_data      (out_data),
    .upstream_fifo_out_valid     (out_valid),
    .upstream_fifo_out_ready     (out_ready),
    .upstream_fifo_in_data       (in_data),
    .upstream_fifo_in_valid      (in_valid),
    .upstream_fifo_in_ready      (in_ready),
    .upstream_has_message_flying (up_flying),
    .upstream_has_odd_clusters   (up_odd)
  );

  typedef struct {
    logic        fl;
    logic        tv;
    logic [19:0] td;
    logic        ordy;
    logic        iv;
    logic [7:0]  id;
    logic        rr;
    logic        e_trdy;
    logic        e_ovld;
    logic [7:0]  e_odat;
    logic        e_irdy;
    logic        e_rvld;
    logic [19:0] e_rdat;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;
  int   tx_hs  = 0;
  int   rx_hs  = 0;

  function automatic vec_t mk(input logic fl, input logic tv, input logic [19:0] td,
                              input logic ordy, input logic iv, input logic [7:0] id,
                              input logic rr, input logic e_trdy, input logic e_ovld,
                              input logic [7:0] e_odat, input logic e_irdy,
                              input logic e_rvld, input logic [19:0] e_rdat);
    vec_t v;
    v.fl = fl; v.tv = tv; v.td = td; v.ordy = ordy; v.iv = iv; v.id = id; v.rr = rr;
    v.e_trdy = e_trdy; v.e_ovld = e_ovld; v.e_odat = e_odat;
    v.e_irdy = e_irdy; v.e_rvld = e_rvld; v.e_rdat = e_rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 0; local_tx_valid = 0; local_tx_data = '0; out_ready = 0;
    in_valid = 0; in_data = '0; local_rx_ready = 0;
    local_has_message_flying = 0; local_has_odd_clusters = 0;
  endtask

  initial begin
    //                fl tv td        or iv id     rr   trdy ovld odat   irdy rvld rdat
    vecs[0]  = mk(0, 1, 20'hABCDE, 1, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[1]  = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'hDE, 1, 0, 20'h0);
    vecs[2]  = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'hBC, 1, 0, 20'h0);
    vecs[3]  = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'h0A, 1, 0, 20'h0);
    vecs[4]  = mk(0, 0, 20'h0,     0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[5]  = mk(0, 1, 20'hABCDE, 0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[6]  = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'hDE, 1, 0, 20'h0);
    vecs[7]  = mk(0, 0, 20'h0,     0, 0, 8'h00, 0,   0, 1, 8'hBC, 1, 0, 20'h0);
    vecs[8]  = mk(0, 0, 20'h0,     0, 0, 8'h00, 0,   0, 1, 8'hBC, 1, 0, 20'h0);
    vecs[9]  = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'hBC, 1, 0, 20'h0);
    vecs[10] = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'h0A, 1, 0, 20'h0);
    vecs[11] = mk(0, 0, 20'h0,     0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[12] = mk(0, 0, 20'h0,     0, 1, 8'h34, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[13] = mk(0, 0, 20'h0,     0, 1, 8'h12, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[14] = mk(0, 0, 20'h0,     0, 1, 8'hF5, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    for (int i = 15; i < 20; i++)
      vecs[i] = mk(0, 0, 20'h0,    0, 1, 8'h77, 0,   1, 0, 8'h00, 0, 1, 20'h51234);
    vecs[20] = mk(0, 0, 20'h0,     0, 1, 8'h77, 1,   1, 0, 8'h00, 0, 1, 20'h51234);
    vecs[21] = mk(0, 0, 20'h0,     0, 1, 8'h77, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[22] = mk(0, 1, 20'h12345, 0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[23] = mk(0, 0, 20'h0,     1, 0, 8'h00, 0,   0, 1, 8'h45, 1, 0, 20'h0);
    vecs[24] = mk(1, 0, 20'h0,     0, 0, 8'h00, 0,   0, 1, 8'h23, 1, 0, 20'h0);
    vecs[25] = mk(0, 1, 20'hFEDCB, 0, 1, 8'h21, 0,   1, 0, 8'h00, 1, 0, 20'h0);
    vecs[26] = mk(0, 0, 20'h0,     1, 1, 8'h43, 0,   0, 1, 8'hCB, 1, 0, 20'h0);
    vecs[27] = mk(0, 0, 20'h0,     1, 1, 8'hA5, 0,   0, 1, 8'hED, 1, 0, 20'h0);
    vecs[28] = mk(0, 0, 20'h0,     1, 0, 8'h00, 1,   0, 1, 8'h0F, 0, 1, 20'h54321);
    vecs[29] = mk(0, 0, 20'h0,     0, 0, 8'h00, 0,   1, 0, 8'h00, 1, 0, 20'h0);

    drive_idle();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset tx_ready",  32'(local_tx_ready), 1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data",  32'(out_data), 0);
    chk("reset in_ready",  32'(in_ready), 1);
    chk("reset rx_valid",  32'(local_rx_valid), 0);
    chk("reset rx_data",   32'(local_rx_data), 0);
    chk("reset flying",    32'(up_flying), 0);
    chk("reset odd",       32'(up_odd), 0);
    reset = 1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      flush = vecs[i].fl; local_tx_valid = vecs[i].tv; local_tx_data = vecs[i].td;
      out_ready = vecs[i].ordy; in_valid = vecs[i].iv; in_data = vecs[i].id;
      local_rx_ready = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d tx_ready", i),  32'(local_tx_ready), 32'(vecs[i].e_trdy));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid),      32'(vecs[i].e_ovld));
      chk($sformatf("v%0d out_data", i),  32'(out_data),       32'(vecs[i].e_odat));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),       32'(vecs[i].e_irdy));
      chk($sformatf("v%0d rx_valid", i),  32'(local_rx_valid), 32'(vecs[i].e_rvld));
      if (vecs[i].e_rvld)
        chk($sformatf("v%0d rx_data", i), 32'(local_rx_data), 32'(vecs[i].e_rdat));
      if (out_valid && out_ready) tx_hs++;
      if (in_valid && in_ready)   rx_hs++;
    end
    chk("tx handshake count", 32'(tx_hs), 10);
    chk("rx handshake count", 32'(rx_hs), 7);

    // Status flags: one-cycle registered latency.
    @(posedge clk); #1;
    drive_idle();
    local_has_odd_clusters = 1;
    #1 chk("odd before edge", 32'(up_odd), 0);
    @(posedge clk); #1;
    chk("odd after edge", 32'(up_odd), 1);
    chk("flying idle", 32'(up_flying), 0);
    in_valid = 1; in_data = 8'h11;
    @(posedge clk); #1;
    in_valid = 0;
    chk("flying in_valid", 32'(up_flying), 1);
    @(posedge clk); #1;
    chk("flying partial rx", 32'(up_flying), 1);
    local_has_odd_clusters = 0; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(posedge clk); #1;
    chk("flying after flush", 32'(up_flying), 0);
    chk("odd cleared", 32'(up_odd), 0);
    local_has_message_flying = 1;
    @(posedge clk); #1;
    local_has_message_flying = 0;
    chk("flying local flag", 32'(up_flying), 1);

    // Asynchronous reset in the middle of TX_SEND.
    local_tx_valid = 1; local_tx_data = 20'hABCDE; out_ready = 0;
    @(posedge clk); #1;
    local_tx_valid = 0;
    chk("pre-reset out_valid", 32'(out_valid), 1);
    #2 reset = 0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 0);
    chk("async reset out_data",  32'(out_data), 0);
    chk("async reset tx_ready",  32'(local_tx_ready), 1);
    chk("async reset in_ready",  32'(in_ready), 1);
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk("post-reset out_valid", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upstream_link_endpoint.md
Name: upstream_link_endpoint

Overview:
Leaf-side counterpart of the hub's per-child downstream port. It sits between a leaf FPGA's local message controller and the physical hub interconnect.
- TX path: serialises one local message into PHY_WIDTH-bit beats toward the hub.
- RX path: reassembles hub beats into a full message for the local controller.
- Status: reports has_message_flying and has_odd_clusters upward so the hub can detect convergence.

Parameters:
MSG_WIDTH, 20, width of one logical message (e.g. MASTER_FIFO_WIDTH of the leaf).
PHY_WIDTH, 8, interconnect physical width (matches the hub's INTERCONNECT_PHYSICAL_WIDTH).
NUM_BEATS, (MSG_WIDTH+PHY_WIDTH-1)/PHY_WIDTH, derived; beats per message; must not be overridden.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of both paths (driven by new_round_start)
local_tx_data  in  MSG_WIDTH  message to send upward
local_tx_valid  in  1  local_tx_data valid
local_tx_ready  out  1  endpoint accepts local_tx_data
local_rx_data  out  MSG_WIDTH  reassembled message from hub
local_rx_valid  out  1  local_rx_data valid
local_rx_ready  in  1  local consumer accepts
local_has_message_flying  in  1  leaf-internal in-flight indication
local_has_odd_clusters  in  1  leaf-internal odd-cluster indication
upstream_fifo_out_data  out  PHY_WIDTH  beat toward hub
upstream_fifo_out_valid  out  1  beat valid
upstream_fifo_out_ready  in  1  hub accepts beat
upstream_fifo_in_data  in  PHY_WIDTH  beat from hub
upstream_fifo_in_valid  in  1  beat valid
upstream_fifo_in_ready  out  1  endpoint accepts beat
upstream_has_message_flying  out  1  aggregated in-flight flag to hub
upstream_has_odd_clusters  out  1  registered odd-cluster flag to hub

Behaviour:
Reset and flush:
- Asynchronous active-low reset on reset.
- Reset values: local_tx_ready=1, local_rx_valid=0, local_rx_data=0, upstream_fifo_out_valid=0, upstream_fifo_out_data=0, upstream_fifo_in_ready=1, both status outputs=0.
- Reset mid-operation discards any partial TX or RX message.
- flush=1 returns both FSMs to their idle state next cycle with reset output values and drops any partial or held message.
- flush has priority over every handshake in the same cycle; a handshake coinciding with flush is lost.

TX FSM (TX_IDLE, TX_SEND):
- TX_IDLE: local_tx_ready=1. On local_tx_valid, latch the message, tx_beat=0, go to TX_SEND.
- Latency: message accepted in cycle t → beat 0 valid in cycle t+1.
- TX_SEND: local_tx_ready=0. upstream_fifo_out_data = message bits [tx_beat*PHY_WIDTH +: PHY_WIDTH]; bits above MSG_WIDTH in the last beat are 0. Beats are sent LSB first.
- Data and valid are held stable until upstream_fifo_out_ready; on acceptance tx_beat increments.
- Acceptance of beat NUM_BEATS-1 returns the FSM to TX_IDLE; local_tx_ready=1 the next cycle (no back-to-back accept).
- NUM_BEATS=1 is legal: one beat, then TX_IDLE.

RX FSM (RX_COLLECT, RX_HOLD):
- RX_COLLECT: upstream_fifo_in_ready=1. Each accepted beat is written to its slice of the assembly register; rx_beat increments.
- The last beat's padding bits are discarded.
- Accepting beat NUM_BEATS-1 in cycle t → RX_HOLD, local_rx_valid=1 in cycle t+1.
- RX_HOLD: upstream_fifo_in_ready=0; local_rx_data is stable.
- On local_rx_ready, clear rx_beat and return to RX_COLLECT next cycle; no bypass.
- A beat arriving while in RX_HOLD stalls at the hub (ready=0) and is never dropped.

Status outputs (registered, 1-cycle latency):
- upstream_has_message_flying is the OR of: local_has_message_flying, TX not idle, local_tx_valid, RX in RX_HOLD, rx_beat≠0, upstream_fifo_in_valid.
- upstream_has_odd_clusters <= local_has_odd_clusters.

General:
- TX and RX are fully independent; simultaneous activity on both is required to work.
- Counter width: $clog2(NUM_BEATS+1); counters never exceed NUM_BEATS-1.

Decomposition:
- Shared package qec_link_pkg: TX and RX state enums; a function ceil_div for NUM_BEATS; the beat-counter width constant.
- One natural sub-module, link_beat_deserializer (the RX path). The TX path and status logic stay inline.

Test Plan:
1. MSG_WIDTH=20, PHY_WIDTH=8, local_tx_data=20'hABCDE, out_ready=1 → beats 8'hDE, 8'hBC, 8'h0A on consecutive cycles t+1..t+3; local_tx_ready=1 at t+4.
2. Same message with out_ready toggling 1,0,0,1,1 → each beat held stable while ready=0; exactly 3 handshakes; no duplicates.
3. Hub sends beats 8'h34, 8'h12, 8'hF5 → local_rx_data=20'h51234; local_rx_valid rises the cycle after the third beat.
4. local_rx_ready held 0 for 5 cycles with a fourth beat pending → upstream_fifo_in_ready=0 throughout; the beat is accepted only after the release cycle plus one.
5. flush asserted mid-TX (after beat 1) and mid-RX (after 1 beat) → next cycle out_valid=0, in_ready=1, rx_beat=0; a fresh message afterwards is sent and received correctly.
6. Reset asserted during TX_SEND → outputs take reset values immediately (asynchronously). Status: local_has_odd_clusters=1 → upstream_has_odd_clusters=1 one cycle later; with all paths idle and local flag 0, upstream_has_message_flying=0.
